// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I multicycle control FSM.
// The TRAP state exists only when CTRL_TRAP_EN is defined.
package ctrl_pkg;

  typedef enum logic [2:0] {
    START,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
`ifdef CTRL_TRAP_EN
    , TRAP
`endif
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ADD   = 4'd0,
    SUB   = 4'd1,
    SLL   = 4'd2,
    SLT   = 4'd3,
    SLTU  = 4'd4,
    XOR   = 4'd5,
    SRL   = 4'd6,
    SRA   = 4'd7,
    OR    = 4'd8,
    AND   = 4'd9,
    PASSB = 4'd10
  } alu_t;

  typedef enum logic [3:0] {
    CL_R,
    CL_I,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JAL,
    CL_JALR,
    CL_LUI,
    CL_AUIPC,
    CL_ILL
  } cls_t;

  localparam logic [1:0] PC_SEL_PC4  = 2'd0;
  localparam logic [1:0] PC_SEL_ALU  = 2'd1;
  localparam logic [1:0] PC_SEL_JALR = 2'd2;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  // Anything outside the nine handled opcodes is treated as illegal.
  function automatic cls_t classify(input logic [6:0] opcode);
    cls_t c;
    case (opcode)
      OP_R:      c = CL_R;
      OP_I:      c = CL_I;
      OP_LOAD:   c = CL_LOAD;
      OP_STORE:  c = CL_STORE;
      OP_BRANCH: c = CL_BRANCH;
      OP_JAL:    c = CL_JAL;
      OP_JALR:   c = CL_JALR;
      OP_LUI:    c = CL_LUI;
      OP_AUIPC:  c = CL_AUIPC;
      default:   c = CL_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_op_decoder.sv
// Combinational map from instruction class, funct3 and funct7[5] to the ALU
// operation code.
module alu_op_decoder
  import ctrl_pkg::*;
(
  input  logic [3:0] cls,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_ctrl
);

  cls_t cls_e;
  alu_t op;

  assign cls_e    = cls_t'(cls);
  assign alu_ctrl = op;

  always_comb begin
    op = ADD;
    case (cls_e)
      CL_R, CL_I: begin
        case (funct3)
          // For I-type, bit 30 belongs to the immediate except on shifts.
          3'b000:  op = (cls_e == CL_R && funct7_5) ? SUB : ADD;
          3'b001:  op = SLL;
          3'b010:  op = SLT;
          3'b011:  op = SLTU;
          3'b100:  op = XOR;
          3'b101:  op = funct7_5 ? SRA : SRL;
          3'b110:  op = OR;
          default: op = AND;
        endcase
      end
      CL_LUI:  op = PASSB;
      default: op = ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for an RV32I core: fetch, decode, execute, memory, write-back.
// Optional feature macro CTRL_TRAP_EN: illegal opcodes park the FSM in TRAP.
//
// state  | meaning
// START  | reset state, all outputs 0
// FETCH  | instruction request, IR load on ready
// DECODE | IR valid, classify opcode
// EXEC   | ALU controls driven; branches resolve here
// MEM    | data memory access, waits for ready
// WB     | register write-back and PC update
// TRAP   | illegal opcode seen, held until reset (CTRL_TRAP_EN only)
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       i_rst,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  input  logic       i_br_taken,
  input  logic       i_imem_ready,
  input  logic       i_dmem_ready,
  output logic       o_imem_req,
  output logic       o_ir_we,
  output logic       o_dmem_req,
  output logic       o_dmem_we,
  output logic       o_rf_we,
  output logic       o_pc_we,
  output logic [1:0] o_pc_sel,
  output logic       o_alu_src_a,
  output logic       o_alu_src_b,
  output logic [2:0] o_imm_sel,
  output logic [3:0] o_alu_ctrl,
  output logic [1:0] o_wb_sel,
  output logic       o_illegal
);

  state_t     state;
  state_t     state_nxt;
  cls_t       cls;
  logic       drive_alu;
  logic [3:0] alu_op;
  logic       src_a;
  logic       src_b;
  logic [2:0] imm_sel;
  logic       unused_funct7;

  assign cls           = classify(i_opcode);
  assign unused_funct7 = ^{i_funct7[6], i_funct7[4:0]};

  alu_op_decoder u_alu_op_decoder (
    .cls      (cls),
    .funct3   (i_funct3),
    .funct7_5 (i_funct7[5]),
    .alu_ctrl (alu_op)
  );

  always_ff @(posedge clk) begin
    if (!i_rst) begin
      state <= START;
    end else begin
      state <= state_nxt;
    end
  end

  // ALU operand selection is a pure function of the class; it is presented
  // from EXEC through MEM/WB so the datapath result stays stable.
  always_comb begin
    src_a   = 1'b0;
    src_b   = 1'b0;
    imm_sel = IMM_I;
    case (cls)
      CL_I:      begin src_b = 1'b1; imm_sel = IMM_I; end
      CL_LOAD:   begin src_b = 1'b1; imm_sel = IMM_I; end
      CL_STORE:  begin src_b = 1'b1; imm_sel = IMM_S; end
      CL_LUI:    begin src_b = 1'b1; imm_sel = IMM_U; end
      CL_AUIPC:  begin src_a = 1'b1; src_b = 1'b1; imm_sel = IMM_U; end
      CL_BRANCH: begin src_a = 1'b1; src_b = 1'b1; imm_sel = IMM_B; end
      CL_JAL:    begin src_a = 1'b1; src_b = 1'b1; imm_sel = IMM_J; end
      CL_JALR:   begin src_b = 1'b1; imm_sel = IMM_I; end
      default:   ;
    endcase
  end

  assign drive_alu   = (state == EXEC) || (state == MEM) || (state == WB);
  assign o_alu_src_a = drive_alu & src_a;
  assign o_alu_src_b = drive_alu & src_b;
  assign o_imm_sel   = drive_alu ? imm_sel : 3'd0;
  assign o_alu_ctrl  = drive_alu ? alu_op : 4'd0;

  always_comb begin
    state_nxt  = state;
    o_imem_req = 1'b0;
    o_ir_we    = 1'b0;
    o_dmem_req = 1'b0;
    o_dmem_we  = 1'b0;
    o_rf_we    = 1'b0;
    o_pc_we    = 1'b0;
    o_pc_sel   = PC_SEL_PC4;
    o_wb_sel   = WB_ALU;
    case (state)
      START: state_nxt = FETCH;
      FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ready) begin
          o_ir_we   = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        if (cls == CL_ILL) begin
`ifdef CTRL_TRAP_EN
          state_nxt = TRAP;
`else
          state_nxt = WB;
`endif
        end else begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        case (cls)
          CL_LOAD, CL_STORE: state_nxt = MEM;
          CL_BRANCH: begin
            o_pc_we   = 1'b1;
            o_pc_sel  = i_br_taken ? PC_SEL_ALU : PC_SEL_PC4;
            state_nxt = FETCH;
          end
          default: state_nxt = WB;
        endcase
      end
      MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = (cls == CL_STORE);
        if (i_dmem_ready) begin
          if (cls == CL_STORE) begin
            o_pc_we   = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = WB;
          end
        end
      end
      WB: begin
        // Illegal opcodes without trapping retire here as a NOP.
        o_rf_we   = (cls != CL_ILL);
        o_pc_we   = 1'b1;
        state_nxt = FETCH;
        case (cls)
          CL_LOAD: o_wb_sel = WB_LOAD;
          CL_JAL: begin
            o_wb_sel = WB_PC4;
            o_pc_sel = PC_SEL_ALU;
          end
          CL_JALR: begin
            o_wb_sel = WB_PC4;
            o_pc_sel = PC_SEL_JALR;
          end
          default: ;
        endcase
      end
`ifdef CTRL_TRAP_EN
      TRAP: state_nxt = TRAP;
`endif
      default: state_nxt = START;
    endcase
  end

`ifdef CTRL_TRAP_EN
  assign o_illegal = (state == TRAP);
`else
  assign o_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl; every output is packed into one
// word and compared each cycle against hand-computed values.
module tb_multicycle_ctrl;

  logic       clk;
  logic       i_rst;
  logic [6:0] i_opcode;
  logic [2:0] i_funct3;
  logic [6:0] i_funct7;
  logic       i_br_taken;
  logic       i_imem_ready;
  logic       i_dmem_ready;
  logic       o_imem_req;
  logic       o_ir_we;
  logic       o_dmem_req;
  logic       o_dmem_we;
  logic       o_rf_we;
  logic       o_pc_we;
  logic [1:0] o_pc_sel;
  logic       o_alu_src_a;
  logic       o_alu_src_b;
  logic [2:0] o_imm_sel;
  logic [3:0] o_alu_ctrl;
  logic [1:0] o_wb_sel;
  logic       o_illegal;

  int n_vec = 0;
  int n_err = 0;

  multicycle_ctrl dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_opcode     (i_opcode),
    .i_funct3     (i_funct3),
    .i_funct7     (i_funct7),
    .i_br_taken   (i_br_taken),
    .i_imem_ready (i_imem_ready),
    .i_dmem_ready (i_dmem_ready),
    .o_imem_req   (o_imem_req),
    .o_ir_we      (o_ir_we),
    .o_dmem_req   (o_dmem_req),
    .o_dmem_we    (o_dmem_we),
    .o_rf_we      (o_rf_we),
    .o_pc_we      (o_pc_we),
    .o_pc_sel     (o_pc_sel),
    .o_alu_src_a  (o_alu_src_a),
    .o_alu_src_b  (o_alu_src_b),
    .o_imm_sel    (o_imm_sel),
    .o_alu_ctrl   (o_alu_ctrl),
    .o_wb_sel     (o_wb_sel),
    .o_illegal    (o_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel[1:0],
  //  src_a, src_b, imm_sel[2:0], alu_ctrl[3:0], wb_sel[1:0], illegal}
  logic [19:0] obs;
  assign obs = {o_imem_req, o_ir_we, o_dmem_req, o_dmem_we, o_rf_we, o_pc_we,
                o_pc_sel, o_alu_src_a, o_alu_src_b, o_imm_sel, o_alu_ctrl,
                o_wb_sel, o_illegal};

  localparam logic [19:0] IMR = 20'h80000;
  localparam logic [19:0] IRW = 20'h40000;
  localparam logic [19:0] DMR = 20'h20000;
  localparam logic [19:0] DMW = 20'h10000;
  localparam logic [19:0] RFW = 20'h08000;
  localparam logic [19:0] PCW = 20'h04000;
  localparam logic [19:0] SA  = 20'h00800;
  localparam logic [19:0] SB  = 20'h00400;
  localparam logic [19:0] ILL = 20'h00001;

  function automatic logic [19:0] f_pcs(input logic [1:0] v);
    return {6'b0, v, 12'b0};
  endfunction
  function automatic logic [19:0] f_imm(input logic [2:0] v);
    return {10'b0, v, 7'b0};
  endfunction
  function automatic logic [19:0] f_alu(input logic [3:0] v);
    return {13'b0, v, 3'b0};
  endfunction
  function automatic logic [19:0] f_wb(input logic [1:0] v);
    return {17'b0, v, 1'b0};
  endfunction

  task automatic check_vec(input string tag, input logic [19:0] got,
                           input logic [19:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  // Check the current cycle, then advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic [19:0] exp);
    #1;
    check_vec(tag, obs, exp);
    @(posedge clk);
    #2;
  endtask

  task automatic set_ir(input logic [31:0] w);
    i_opcode = w[6:0];
    i_funct3 = w[14:12];
    i_funct7 = w[31:25];
  endtask

  initial begin
    i_rst        = 1'b0;
    i_br_taken   = 1'b0;
    i_imem_ready = 1'b1;
    i_dmem_ready = 1'b1;
    set_ir(32'h0000_0013);
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    cyc("reset", 20'h0);

    i_rst = 1'b1;
    set_ir(32'h002081B3);                 // add x3,x1,x2
    cyc("start", 20'h0);
    cyc("add_fetch", IMR | IRW);
    cyc("add_decode", 20'h0);
    cyc("add_exec", f_alu(4'd0));
    cyc("add_wb", RFW | PCW);

    set_ir(32'h402081B3);                 // sub x3,x1,x2
    cyc("sub_fetch", IMR | IRW);
    cyc("sub_decode", 20'h0);
    cyc("sub_exec", f_alu(4'd1));
    cyc("sub_wb", RFW | PCW | f_alu(4'd1));

    set_ir(32'h4030D093);                 // srai x1,x1,3
    cyc("srai_fetch", IMR | IRW);
    cyc("srai_decode", 20'h0);
    cyc("srai_exec", SB | f_alu(4'd7));
    cyc("srai_wb", RFW | PCW | SB | f_alu(4'd7));

    set_ir(32'hC0008093);                 // addi x1,x1,-1024 (bit 30 set)
    cyc("addi_fetch", IMR | IRW);
    cyc("addi_decode", 20'h0);
    cyc("addi_exec", SB);
    cyc("addi_wb", RFW | PCW | SB);

    set_ir(32'h0040A283);                 // lw x5,4(x1)
    i_imem_ready = 1'b0;
    cyc("lw_fetch_wait", IMR);
    i_imem_ready = 1'b1;
    cyc("lw_fetch", IMR | IRW);
    cyc("lw_decode", 20'h0);
    cyc("lw_exec", SB);
    i_dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lw_mem_wait", DMR | SB);
    i_dmem_ready = 1'b1;
    cyc("lw_mem", DMR | SB);
    cyc("lw_wb", RFW | PCW | SB | f_wb(2'd1));

    set_ir(32'h00000463);                 // beq x0,x0,+8
    i_br_taken = 1'b1;
    cyc("beq_t_fetch", IMR | IRW);
    cyc("beq_t_decode", 20'h0);
    cyc("beq_t_exec", PCW | f_pcs(2'd1) | SA | SB | f_imm(3'd2));
    i_br_taken = 1'b0;
    cyc("beq_n_fetch", IMR | IRW);
    cyc("beq_n_decode", 20'h0);
    cyc("beq_n_exec", PCW | SA | SB | f_imm(3'd2));

    set_ir(32'h000100E7);                 // jalr x1,0(x2)
    cyc("jalr_fetch", IMR | IRW);
    cyc("jalr_decode", 20'h0);
    cyc("jalr_exec", SB);
    cyc("jalr_wb", RFW | PCW | f_pcs(2'd2) | SB | f_wb(2'd2));

    set_ir(32'h010000EF);                 // jal x1,+16
    cyc("jal_fetch", IMR | IRW);
    cyc("jal_decode", 20'h0);
    cyc("jal_exec", SA | SB | f_imm(3'd4));
    cyc("jal_wb", RFW | PCW | f_pcs(2'd1) | SA | SB | f_imm(3'd4) | f_wb(2'd2));

    set_ir(32'h123450B7);                 // lui x1,0x12345
    cyc("lui_fetch", IMR | IRW);
    cyc("lui_decode", 20'h0);
    cyc("lui_exec", SB | f_imm(3'd3) | f_alu(4'd10));
    cyc("lui_wb", RFW | PCW | SB | f_imm(3'd3) | f_alu(4'd10));

    set_ir(32'h00001097);                 // auipc x1,1
    cyc("auipc_fetch", IMR | IRW);
    cyc("auipc_decode", 20'h0);
    cyc("auipc_exec", SA | SB | f_imm(3'd3));
    cyc("auipc_wb", RFW | PCW | SA | SB | f_imm(3'd3));

    set_ir(32'h0020A223);                 // sw x2,4(x1)
    cyc("sw_fetch", IMR | IRW);
    cyc("sw_decode", 20'h0);
    cyc("sw_exec", SB | f_imm(3'd1));
    cyc("sw_mem", DMR | DMW | PCW | SB | f_imm(3'd1));

    // Second store: reset arrives while the data request is pending.
    cyc("sw2_fetch", IMR | IRW);
    cyc("sw2_decode", 20'h0);
    cyc("sw2_exec", SB | f_imm(3'd1));
    i_dmem_ready = 1'b0;
    cyc("sw2_mem_wait", DMR | DMW | SB | f_imm(3'd1));
    i_rst = 1'b0;
    cyc("sw2_mem_rst", DMR | DMW | SB | f_imm(3'd1));
    i_dmem_ready = 1'b1;
    cyc("sw2_in_reset", 20'h0);
    i_rst = 1'b1;
    set_ir(32'h0000007F);
    cyc("rst_start", 20'h0);
    cyc("ill_fetch", IMR | IRW);
    cyc("ill_decode", 20'h0);
`ifdef CTRL_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      i_imem_ready = i[0];
      cyc("ill_trap", ILL);
    end
    i_imem_ready = 1'b1;
`else
    cyc("ill_nop", PCW);
    cyc("ill_next_fetch", IMR | IRW);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM for the RV32I microprocessor. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives the instruction register write enable and every datapath select and enable, from the opcode/funct fields the IR decoder produces. It sits between the instruction/data memory ports, the IR decoder, the register file, the ALU and the PC register.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-low.
- i_opcode  in  7  from IR decoder.
- i_funct3  in  3  from IR decoder.
- i_funct7  in  7  from IR decoder; only bit 5 is used.
- i_br_taken  in  1  branch comparator result for current funct3.
- i_imem_ready  in  1  instruction memory data valid.
- i_dmem_ready  in  1  data memory access complete.
- o_imem_req  out  1  instruction fetch request.
- o_ir_we  out  1  IR write enable (i_we of the decoder).
- o_dmem_req  out  1  data memory request.
- o_dmem_we  out  1  data memory write (store).
- o_rf_we  out  1  register file write enable.
- o_pc_we  out  1  PC write enable.
- o_pc_sel  out  2  0 = PC+4, 1 = ALU result (branch/JAL target), 2 = ALU result & ~1 (JALR).
- o_alu_src_a  out  1  0 = rs1, 1 = PC.
- o_alu_src_b  out  1  0 = rs2, 1 = immediate.
- o_imm_sel  out  3  0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
- o_alu_ctrl  out  4  ALU operation code (package enum).
- o_wb_sel  out  2  0 = ALU, 1 = load data, 2 = PC+4.
- o_illegal  out  1  illegal opcode flag (see Configuration).

## Operation
- States: START, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- START: reset state; all outputs 0; goes to FETCH unconditionally.
- FETCH: o_imem_req = 1. When i_imem_ready = 1, o_ir_we = 1 that cycle and the FSM goes to DECODE. Otherwise it stays in FETCH.
- DECODE: IR fields are valid. The FSM classifies the opcode and goes to EXEC; an illegal opcode is handled per Configuration.
- EXEC: ALU controls are driven per class.
  - R: src_a = 0, src_b = 0, alu_ctrl from funct3 and funct7[5].
  - I-ALU: src_b = 1, imm I; funct7[5] is used only for SRAI.
  - LOAD / STORE: ADD, imm I or S. Next state is MEM.
  - LUI: alu_ctrl PASSB, imm U.
  - AUIPC: src_a = 1, ADD, imm U.
  - BRANCH: src_a = 1, imm B, ADD. o_pc_we = 1 and o_pc_sel = i_br_taken ? 1 : 0. Next state is FETCH.
  - JAL: src_a = 1, imm J. Next state is WB.
  - JALR: src_a = 0, imm I. Next state is WB.
  - All other classes go to WB.
- MEM: o_dmem_req = 1; o_dmem_we = 1 for STORE. ALU controls are held from EXEC. The FSM waits for i_dmem_ready.
  - LOAD then goes to WB.
  - STORE asserts o_pc_we with pc_sel 0 on the ready cycle and goes to FETCH.
- WB: o_rf_we = 1 and o_pc_we = 1, then FETCH. ALU controls are held from EXEC.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, otherwise 0.
  - pc_sel: 1 for JAL, 2 for JALR, otherwise 0.
- Outputs are combinational from the state and the decoded IR fields. Enables and requests are 0 outside the states listed above.
- x0 write suppression is owned by the register file, not by this block.

## Timing
- Reset: while i_rst = 0 at a clk edge, the state becomes START and every output is 0. This includes reset mid-MEM or mid-FETCH: the pending request drops on the following cycle and no retry state is kept.
- The first o_imem_req is asserted 1 cycle after reset is released.
- Latency with zero wait states, in cycles from FETCH entry to the next FETCH entry:
  - ALU, LUI, AUIPC, JAL, JALR: 4.
  - Branch: 3.
  - Store: 4.
  - Load: 5.
- Each cycle that i_imem_ready or i_dmem_ready is low adds one cycle.
- Handshake: requests stay asserted until the ready input is sampled high. Ready is ignored in all other states.
- o_ir_we is a single-cycle pulse per instruction. The IR is stable from DECODE until the next FETCH completes.

## Configuration
- CTRL_TRAP_EN defined:
  - An opcode outside the RV32I set in DECODE goes to TRAP.
  - In TRAP, o_illegal = 1, all enables and requests are 0, and the FSM stays there until reset.
- CTRL_TRAP_EN undefined:
  - An illegal opcode is executed as a NOP: DECODE → WB with o_rf_we = 0, o_pc_we = 1, pc_sel 0.
  - o_illegal is tied to 0 and the TRAP state is not built.

## Structure
- Package ctrl_pkg holds:
  - The state enum.
  - Opcode localparams: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC.
  - The ALU code enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB.
  - The encodings for pc_sel, imm_sel and wb_sel.
- Sub-module alu_op_decoder: combinational map from opcode class, funct3 and funct7[5] to o_alu_ctrl.

## Test plan
- add x3,x1,x2 (0x002081B3) with ready always 1 → ir_we in cycle 1 after START, alu_ctrl = ADD, rf_we and pc_we with wb_sel 0 in cycle 4, back to FETCH in cycle 5.
- lw x5,4(x1) (0x0040A283) with i_dmem_ready low for 3 MEM cycles → dmem_req held 4 cycles, dmem_we = 0, WB with wb_sel 1, total 8 cycles.
- beq x0,x0,+8 (0x00000463) with i_br_taken = 1 → pc_we, pc_sel 1 and imm_sel 2 in EXEC, no rf_we, FETCH next. Repeat with taken = 0 → pc_sel 0.
- jalr x1,0(x2) (0x000100E7) → WB asserts rf_we, wb_sel 2, pc_sel 2.
- Instruction 0x0000007F: with CTRL_TRAP_EN, o_illegal = 1 forever and all enables 0. Without it, one pc_we with pc_sel 0 and rf_we never asserted.
- i_rst low during MEM of sw (0x0020A223) → next cycle all outputs 0, START; FETCH follows after release.
